// File: rtl/mlp_pkg.sv
// Shared types and helpers for the dense MLP layer: FSM state encoding,
// default geometry and group/latency arithmetic.
package mlp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_MAC    = 3'd2,
      ST_ARGMAX = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int DEF_IN_DIM  = 64;
   localparam int DEF_OUT_DIM = 10;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_ACC_W   = 32;
   localparam int DEF_LANES   = 2;

   function automatic int num_groups(input int out_dim, input int lanes);
      return out_dim / lanes;
   endfunction

   // Cycles from the start-accepting edge to the done pulse.
   function automatic int run_latency(input int in_dim, input int out_dim, input int lanes);
      return num_groups(out_dim, lanes) * (in_dim + 1) + out_dim + 2;
   endfunction

endpackage

// File: rtl/mlp_mac_lane.sv
// One signed multiply-accumulate lane; sum_o is the accumulator plus the
// current product, which becomes the new accumulator when en_i is high.
module mlp_mac_lane
   import mlp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   output logic signed [ACC_W-1:0]  sum_o
);

   logic signed [2*DATA_W-1:0] a_ext_s;
   logic signed [2*DATA_W-1:0] b_ext_s;
   logic signed [2*DATA_W-1:0] prod_s;
   logic signed [ACC_W-1:0]    prod_ext_s;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [ACC_W-1:0]    acc_d;

   // Operands are widened first so the product keeps its full signed range.
   always_comb begin
      a_ext_s    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
      b_ext_s    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
      prod_s     = a_ext_s * b_ext_s;
      prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
      sum_o      = acc_q + prod_ext_s;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = sum_o;
      end else begin
         acc_d = acc_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/mlp_dense_layer.sv
// Sequential dense layer with LANES parallel MAC lanes and argmax readout.
// Define MLP_RELU_EN to clamp negative logits to zero before storage/argmax.
module mlp_dense_layer
   import mlp_pkg::*;
#(
   parameter int IN_DIM  = DEF_IN_DIM,
   parameter int OUT_DIM = DEF_OUT_DIM,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int LANES   = DEF_LANES
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [DATA_W*IN_DIM-1:0]                  bus_in,
   output logic [$clog2(IN_DIM*OUT_DIM/LANES)-1:0]   w_addr,
   input  logic [LANES*DATA_W-1:0]                   w_data,
   output logic                                      busy,
   output logic                                      done,
   output logic [OUT_DIM*ACC_W-1:0]                  logits,
   output logic [$clog2(OUT_DIM)-1:0]                class_idx,
   output logic [OUT_DIM-1:0]                        one_out
);

   localparam int GROUPS = num_groups(OUT_DIM, LANES);
   localparam int ADDR_W = $clog2(IN_DIM*OUT_DIM/LANES);
   localparam int FEAT_W = $clog2(IN_DIM+1);
   localparam int XI_W   = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
   localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int IDX_W  = $clog2(OUT_DIM);

   localparam logic [FEAT_W-1:0]  FEAT_LAST = FEAT_W'(IN_DIM);
   localparam logic [FEAT_W-1:0]  FEAT_PEN  = FEAT_W'(IN_DIM-1);
   localparam logic [GRP_W-1:0]   GRP_LAST  = GRP_W'(GROUPS-1);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(OUT_DIM-1);
   localparam logic [OUT_DIM-1:0] ONE_HOT0  = {{(OUT_DIM-1){1'b0}}, 1'b1};

   state_t                     state_q, state_d;
   logic signed [DATA_W-1:0]   x_q [IN_DIM];
   logic signed [ACC_W-1:0]    buf_q [OUT_DIM];
   logic [FEAT_W-1:0]          feat_q;
   logic [GRP_W-1:0]           grp_q;
   logic [IDX_W-1:0]           idx_q;
   logic [ADDR_W-1:0]          w_addr_q;
   logic signed [ACC_W-1:0]    best_q;
   logic [IDX_W-1:0]           best_idx_q;
   logic                       busy_q;
   logic                       done_q;
   logic [OUT_DIM*ACC_W-1:0]   logits_q;
   logic [IDX_W-1:0]           class_q;
   logic [OUT_DIM-1:0]         one_out_q;

   logic                       lane_clr_s;
   logic                       lane_en_s;
   logic [XI_W-1:0]            x_idx_s;
   logic signed [DATA_W-1:0]   x_cur_s;
   logic signed [DATA_W-1:0]   lane_w_s   [LANES];
   logic signed [ACC_W-1:0]    lane_sum_s [LANES];
   logic signed [ACC_W-1:0]    lane_val_s [LANES];

   assign w_addr    = w_addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign logits    = logits_q;
   assign class_idx = class_q;
   assign one_out   = one_out_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: state_d = ST_MAC;
         ST_MAC: begin
            if ((feat_q == FEAT_LAST) && (grp_q == GRP_LAST)) begin
               state_d = ST_ARGMAX;
            end else begin
               state_d = ST_MAC;
            end
         end
         ST_ARGMAX: begin
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ARGMAX;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Feature 0 of a group only issues its address; data for feature j-1 arrives at feat_q == j.
   always_comb begin
      lane_clr_s = (state_q == ST_MAC) && (feat_q == '0);
      lane_en_s  = (state_q == ST_MAC) && (feat_q != '0);
      if (feat_q != '0) begin
         x_idx_s = XI_W'(feat_q - 1'b1);
      end else begin
         x_idx_s = '0;
      end
      x_cur_s = x_q[x_idx_s];
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_w_s[k] = w_data[k*DATA_W +: DATA_W];

      mlp_mac_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk_i  (clk),
         .rst_i  (rst),
         .clr_i  (lane_clr_s),
         .en_i   (lane_en_s),
         .a_i    (x_cur_s),
         .b_i    (lane_w_s[k]),
         .sum_o  (lane_sum_s[k])
      );
   end

   // Value written into the logit buffer at the end of each group.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
`ifdef MLP_RELU_EN
         if (lane_sum_s[k][ACC_W-1]) begin
            lane_val_s[k] = '0;
         end else begin
            lane_val_s[k] = lane_sum_s[k];
         end
`else
         lane_val_s[k] = lane_sum_s[k];
`endif
      end
   end

   // Datapath: input latch, counters/address, logit store, argmax scan, result commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IN_DIM; i++) begin
            x_q[i] <= '0;
         end
         for (int n = 0; n < OUT_DIM; n++) begin
            buf_q[n] <= '0;
         end
         feat_q     <= '0;
         grp_q      <= '0;
         idx_q      <= '0;
         w_addr_q   <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         logits_q   <= '0;
         class_q    <= '0;
         one_out_q  <= ONE_HOT0;
      end else begin
         done_q <= 1'b0;
         busy_q <= (state_d != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  for (int i = 0; i < IN_DIM; i++) begin
                     x_q[i] <= bus_in[i*DATA_W +: DATA_W];
                  end
               end
            end
            ST_LOAD: begin
               feat_q   <= '0;
               grp_q    <= '0;
               w_addr_q <= '0;
            end
            ST_MAC: begin
               if (feat_q == FEAT_LAST) begin
                  for (int n = 0; n < OUT_DIM; n++) begin
                     if (GRP_W'(n / LANES) == grp_q) begin
                        buf_q[n] <= lane_val_s[n % LANES];
                     end
                  end
                  feat_q <= '0;
                  idx_q  <= '0;
                  if (grp_q != GRP_LAST) begin
                     grp_q    <= grp_q + 1'b1;
                     w_addr_q <= w_addr_q + 1'b1;
                  end
               end else begin
                  feat_q <= feat_q + 1'b1;
                  // Hold the address during the trailing data-only cycle of a group.
                  if (feat_q != FEAT_PEN) begin
                     w_addr_q <= w_addr_q + 1'b1;
                  end
               end
            end
            ST_ARGMAX: begin
               if ((idx_q == '0) || (buf_q[idx_q] > best_q)) begin
                  best_q     <= buf_q[idx_q];
                  best_idx_q <= idx_q;
               end
               idx_q <= idx_q + 1'b1;
            end
            ST_DONE: begin
               for (int n = 0; n < OUT_DIM; n++) begin
                  logits_q[n*ACC_W +: ACC_W] <= buf_q[n];
               end
               class_q   <= best_idx_q;
               one_out_q <= ONE_HOT0 << best_idx_q;
               done_q    <= 1'b1;
            end
            default: begin
               done_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mlp_dense_layer.md
MLP_DENSE_LAYER -- requirements
Module: mlp_dense_layer

Interface
REQ-001 SHALL have parameter IN_DIM, default 64, number of input features.
REQ-002 SHALL have parameter OUT_DIM, default 10, number of output neurons.
REQ-003 SHALL have parameter DATA_W, default 8, signed input/weight width.
REQ-004 SHALL have parameter ACC_W, default 32, signed accumulator/logit width.
REQ-005 SHALL have parameter LANES, default 2, parallel MAC lanes; OUT_DIM % LANES == 0.
REQ-006 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  in  1  single-cycle run request.
REQ-009 SHALL have port bus_in  in  DATA_W*IN_DIM  input vector; feature i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port w_addr  out  clog2(IN_DIM*OUT_DIM/LANES)  weight memory address.
REQ-011 SHALL have port w_data  in  LANES*DATA_W  weight word; lane k at [k*DATA_W +: DATA_W].
REQ-012 SHALL have port busy  out  1  high from the cycle after accepted start until done.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port logits  out  OUT_DIM*ACC_W  signed results; neuron n at [n*ACC_W +: ACC_W].
REQ-015 SHALL have port class_idx  out  clog2(OUT_DIM)  argmax index.
REQ-016 SHALL have port one_out  out  OUT_DIM  one-hot of class_idx.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> MAC -> ARGMAX -> DONE -> IDLE.
REQ-018 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-019 SHALL latch bus_in on the accepting edge; later bus_in changes do not affect the run.
REQ-020 SHALL process OUT_DIM/LANES groups; group g, feature i reads w_addr = g*IN_DIM + i; lane k computes neuron g*LANES + k.
REQ-021 SHALL treat w_data as valid exactly one cycle after w_addr (synchronous read); each group takes IN_DIM+1 cycles.
REQ-022 SHALL compute logit = sum(signed input * signed weight), sign-extended to ACC_W, no bias; ACC_W >= 2*DATA_W+clog2(IN_DIM) guarantees no overflow.
REQ-023 SHALL scan logits sequentially in ARGMAX, one per cycle (OUT_DIM cycles); strictly-greater comparison, so ties resolve to lowest index.
REQ-024 SHALL assert done exactly (OUT_DIM/LANES)*(IN_DIM+1) + OUT_DIM + 2 cycles after the start-accepting edge.
REQ-025 SHALL update logits, class_idx, one_out in the done cycle and hold them until the next done.
REQ-026 SHALL accept a start arriving in the done cycle's following IDLE cycle (back-to-back, one idle cycle minimum).

Reset
REQ-027 SHALL on rst force IDLE, busy=0, done=0, logits=0, class_idx=0, one_out=1 (bit 0), w_addr=0, immediately and asynchronously.
REQ-028 SHALL on rst mid-run abandon the run with no done pulse; the first start after rst release runs normally.

Configuration
REQ-029 SHALL, with MLP_RELU_EN defined, clamp each negative logit to 0 before storage and argmax.
REQ-030 SHALL, without MLP_RELU_EN, store and compare raw signed logits.

Structure
REQ-031 SHALL place state enum, default parameter constants and group/latency helper functions in package mlp_pkg.
REQ-032 SHALL instantiate one sub-module mlp_mac_lane (signed multiply-accumulate with clear/enable) per lane.

Verification
REQ-033 SHALL test all weights 0, any input -> logits all 0, class_idx 0, one_out 10'b0000000001, done at cycle 5*65+12=337.
REQ-034 SHALL test input all 0x01, neuron n weights all n -> logit n = 64*n, class_idx 9, one_out 10'b1000000000.
REQ-035 SHALL test neurons 3 and 7 equal maximum -> class_idx 3.
REQ-036 SHALL test input all 0x7F, all weights 0x81 (-127) -> logits -1032256 each without MLP_RELU_EN, 0 with it; class_idx 0.
REQ-037 SHALL test start re-pulsed mid-MAC -> ignored, single done at original latency; rst mid-MAC -> no done, outputs reset, next run correct.
